rx_fsm: RTL
===========

# rx_fsm

USB full/high-speed style serial receiver for the UTMI RX path: the counterpart of the transmit chain (hold reg → shift reg → bit stuffer → NRZI encoder → EOP gen). Samples the differential line pair once per bit clock, then performs SYNC hunt, NRZI decode, bit unstuffing, deserialisation and EOP detection. Delivers bytes with a one-cycle `rx_valid` strobe, framed by `rx_active`, and flags stuffing and framing errors.

## Interface
- `w`, 8, data byte width; the bit counter is `$clog2(w)` bits wide.
- `STUFF_LEN`, 6, number of consecutive decoded 1s after which a stuffed 0 is expected.
- `SYNC_MIN_ZEROS`, 3, minimum decoded 0s before the SYNC-terminating 1.
- `IDLE_J_CNT`, 8, number of consecutive J samples that ends an aborted packet.
- `clk_480mhz`  in  1  bit clock; one line sample per rising edge.
- `rst`  in  1  reset; one clock domain only; reset is synchronous and active-high.
- `dpr`  in  1  D+ line sample.
- `dmr`  in  1  D− line sample.
- `rx_data`  out  w  last received byte, LSB first on the wire; held until the next byte.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid while it is high.
- `rx_active`  out  1  high from SYNC completion to packet end.
- `rx_error`  out  1  one-cycle pulse on a stuff, SE1 or partial-byte error.

## Operation
- Line states: J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1).
- NRZI decode: decoded bit = 1 if the sample equals the previous J/K level, 0 if it differs.
  - The previous level resets to J.
  - The previous level updates only on J/K samples.
- States:
  - IDLE: wait while the line is J. On a K sample, go to SYNC with zero count = 1. SE0 and SE1 stay in IDLE.
  - SYNC: count decoded 0s, saturating at 15.
    - Decoded 1 with count ≥ `SYNC_MIN_ZEROS`: go to DATA and raise `rx_active`.
    - Decoded 1 with count below the minimum: go to IDLE.
    - SE0 or SE1: go to IDLE. No error is reported, because no packet has started.
  - DATA: unstuff and deserialise.
    - The ones counter increments on each decoded 1 and clears on each 0.
    - When the counter reaches `STUFF_LEN`, the next bit must be 0. That 0 is discarded, is not shifted, and clears the counter.
    - If that next bit is 1: pulse `rx_error` and go to ABORT.
    - Kept bits shift into bit position = bit count.
    - On the w-th kept bit: update `rx_data`, pulse `rx_valid`, clear the bit count.
    - SE0: go to EOP. If bit count ≠ 0, also pulse `rx_error`; the partial byte is dropped.
    - SE1: pulse `rx_error` and go to ABORT.
  - EOP: stay on SE0.
    - First J: drop `rx_active`, go to IDLE, and reset the previous level to J.
    - K or SE1: pulse `rx_error` and go to ABORT.
  - ABORT: `rx_active` stays high. Exit to IDLE and drop `rx_active` on either:
    - an SE0 followed by J, or
    - `IDLE_J_CNT` consecutive J samples.
- `rx_error` never coincides with `rx_valid` for the same byte.
- Reset mid-packet: the packet is discarded and no strobe is emitted for it.

## Timing
- All outputs are registered. Decisions are combinational from the current sample plus state and update on the same edge.
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_active`=0, `rx_error`=0, state IDLE, previous level J, all counters 0.
- `rx_active` rises on the edge that samples the SYNC-terminating K, so it is high in the cycle after it.
- `rx_valid` and `rx_data` update on the edge that samples the w-th kept data bit. `rx_valid` is high for exactly one cycle.
  - Minimum spacing between strobes is w cycles; a stuffed bit adds 1.
- `rx_active` falls on the edge sampling the J that ends EOP, or the edge completing the ABORT exit condition.
- `rx_error` is high for exactly one cycle per error. ABORT reports no further errors.
- Simultaneous `rst` with any line event: reset wins.

## Structure
- Package `usb_line_pkg`:
  - line-state enum (J, K, SE0, SE1);
  - `rx_state_t` enum (IDLE, SYNC, DATA, EOP, ABORT);
  - default constants for `STUFF_LEN`, `SYNC_MIN_ZEROS`, `IDLE_J_CNT`;
  - J/K encodings.
- Sub-module `nrzi_decoder`: line classification, previous-level register, and the decoded bit and line-state outputs. Unstuffing, the deserialiser and the FSM stay in `rx_fsm`.

## Test plan
- Reset, then 20 J samples → all outputs stay 0; `rx_valid` never pulses.
- SYNC KJKJKJKK, NRZI of 0xA5, SE0, SE0, J → `rx_active` high after the final SYNC K; one `rx_valid` with `rx_data`=0xA5; `rx_active` low after J; no `rx_error`.
- Bytes 0xFF, 0x01 with a stuffed 0 after the 6th 1 → `rx_valid` twice, `rx_data` 0xFF then 0x01; the stuffed bit is not counted.
- Seven consecutive decoded 1s in DATA → one `rx_error` pulse, no `rx_valid` for that byte; `rx_active` drops after 8 J samples.
- SE0 after 3 data bits of a byte → one `rx_error`, no `rx_valid`; `rx_active` drops on the following J.
- `rst` asserted mid-byte of an 0x3C packet → next cycle all outputs 0 and state IDLE; the following packet 0x5A is received correctly.

Source files
------------

// File: rtl/usb_line_pkg.sv
// Shared line-state, receiver-state and default-constant definitions for the USB RX path.
// Pure types and constants: no latency, no flow control.
package usb_line_pkg;

    localparam logic [1:0] LINE_J = 2'b10;   // {dpr, dmr}
    localparam logic [1:0] LINE_K = 2'b01;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = LINE_K,
        LS_J   = LINE_J,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        ABORT
    } rx_state_t;

    localparam int W_DEF              = 8;
    localparam int STUFF_LEN_DEF      = 6;
    localparam int SYNC_MIN_ZEROS_DEF = 3;
    localparam int IDLE_J_CNT_DEF     = 8;

    function automatic logic is_jk(input line_state_t ls);
        return (ls == LS_J) || (ls == LS_K);
    endfunction

endpackage

// File: rtl/nrzi_decoder.sv
// Line classification and NRZI decode; outputs are combinational from the current sample.
// Previous-level register updates on J/K samples only; no backpressure.
module nrzi_decoder
    import usb_line_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dpr,
    input  logic        dmr,
    input  logic        restore_j,
    output line_state_t line_state,
    output logic        dec_bit
);

    logic prev_j_q;
    logic prev_j_d;

    // dec_bit is only meaningful when line_state is J or K.
    always_comb begin
        line_state = line_state_t'({dpr, dmr});
        dec_bit    = (({dpr, dmr} == LINE_J) == prev_j_q);
        prev_j_d   = prev_j_q;
        if (restore_j) begin
            prev_j_d = 1'b1;
        end else if (is_jk(line_state)) begin
            prev_j_d = (line_state == LS_J);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_j_q <= 1'b1;
        end else begin
            prev_j_q <= prev_j_d;
        end
    end

endmodule

// File: rtl/rx_fsm.sv
// USB RX: SYNC hunt, unstuffing, deserialisation and EOP/abort handling, one line sample per clock.
// Outputs registered on the sampling edge (1-cycle latency); no backpressure, rx_valid is a strobe.
module rx_fsm
    import usb_line_pkg::*;
#(
    parameter int w              = W_DEF,
    parameter int STUFF_LEN      = STUFF_LEN_DEF,
    parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
    parameter int IDLE_J_CNT     = IDLE_J_CNT_DEF
) (
    input  logic         clk_480mhz,
    input  logic         rst,
    input  logic         dpr,
    input  logic         dmr,
    output logic [w-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_active,
    output logic         rx_error
);

    localparam int BCW = $clog2(w);
    localparam int OCW = $clog2(STUFF_LEN + 1);
    localparam int JCW = $clog2(IDLE_J_CNT + 1);

    localparam logic [BCW-1:0] LAST_BIT = BCW'(w - 1);
    localparam logic [OCW-1:0] STUFF_AT = OCW'(STUFF_LEN);
    localparam logic [JCW-1:0] J_LAST   = JCW'(IDLE_J_CNT - 1);
    localparam logic [3:0]     ZMIN     = 4'(SYNC_MIN_ZEROS);

    line_state_t line_state;
    logic        dec_bit;
    logic        restore_j;

    rx_state_t      state_q,     state_d;
    logic [3:0]     zeros_q,     zeros_d;
    logic [OCW-1:0] ones_q,      ones_d;
    logic [BCW-1:0] bit_cnt_q,   bit_cnt_d;
    logic [w-1:0]   shreg_q,     shreg_d;
    logic [JCW-1:0] j_cnt_q,     j_cnt_d;
    logic           se0_seen_q,  se0_seen_d;
    logic [w-1:0]   rx_data_q,   rx_data_d;
    logic           rx_valid_q,  rx_valid_d;
    logic           rx_active_q, rx_active_d;
    logic           rx_error_q,  rx_error_d;
    logic [w-1:0]   byte_v;

    nrzi_decoder u_nrzi (
        .clk        (clk_480mhz),
        .rst        (rst),
        .dpr        (dpr),
        .dmr        (dmr),
        .restore_j  (restore_j),
        .line_state (line_state),
        .dec_bit    (dec_bit)
    );

    always_comb begin
        state_d     = state_q;
        zeros_d     = zeros_q;
        ones_d      = ones_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        j_cnt_d     = j_cnt_q;
        se0_seen_d  = se0_seen_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_active_d = rx_active_q;
        rx_error_d  = 1'b0;
        restore_j   = 1'b0;
        byte_v          = shreg_q;
        byte_v[bit_cnt_q] = dec_bit;

        case (state_q)
            IDLE: begin
                if (line_state == LS_K) begin
                    state_d = SYNC;
                    zeros_d = 4'd1;
                end
            end
            SYNC: begin
                if (!is_jk(line_state)) begin
                    state_d = IDLE;
                end else if (!dec_bit) begin
                    if (zeros_q != 4'hF) zeros_d = zeros_q + 4'd1;
                end else if (zeros_q >= ZMIN) begin
                    state_d     = DATA;
                    rx_active_d = 1'b1;
                    ones_d      = '0;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                case (line_state)
                    LS_SE0: begin
                        state_d    = EOP;
                        rx_error_d = (bit_cnt_q != '0);
                        bit_cnt_d  = '0;
                    end
                    LS_SE1: begin
                        state_d    = ABORT;
                        rx_error_d = 1'b1;
                        j_cnt_d    = '0;
                        se0_seen_d = 1'b0;
                    end
                    default: begin
                        if (ones_q == STUFF_AT) begin
                            // A stuffed bit must be 0 and is dropped without shifting.
                            if (dec_bit) begin
                                state_d    = ABORT;
                                rx_error_d = 1'b1;
                                j_cnt_d    = '0;
                                se0_seen_d = 1'b0;
                            end else begin
                                ones_d = '0;
                            end
                        end else begin
                            ones_d  = dec_bit ? ones_q + 1'b1 : '0;
                            shreg_d = byte_v;
                            if (bit_cnt_q == LAST_BIT) begin
                                rx_data_d  = byte_v;
                                rx_valid_d = 1'b1;
                                bit_cnt_d  = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end
                    end
                endcase
            end
            EOP: begin
                if (line_state == LS_J) begin
                    state_d     = IDLE;
                    rx_active_d = 1'b0;
                    restore_j   = 1'b1;
                end else if (line_state != LS_SE0) begin
                    state_d    = ABORT;
                    rx_error_d = 1'b1;
                    j_cnt_d    = '0;
                    se0_seen_d = 1'b0;
                end
            end
            ABORT: begin
                case (line_state)
                    LS_SE0: begin
                        se0_seen_d = 1'b1;
                        j_cnt_d    = '0;
                    end
                    LS_J: begin
                        if (se0_seen_q || (j_cnt_q == J_LAST)) begin
                            state_d     = IDLE;
                            rx_active_d = 1'b0;
                            j_cnt_d     = '0;
                            se0_seen_d  = 1'b0;
                        end else begin
                            j_cnt_d = j_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        j_cnt_d    = '0;
                        se0_seen_d = 1'b0;
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_480mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            zeros_q     <= '0;
            ones_q      <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            j_cnt_q     <= '0;
            se0_seen_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            j_cnt_q     <= j_cnt_d;
            se0_seen_q  <= se0_seen_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_active = rx_active_q;
    assign rx_error  = rx_error_q;

endmodule
